// File: rtl/arbitro_cajero.sv
// Round-robin session arbiter sharing one cajero transaction core among N_TERM card terminals.
// One session at a time; terminals whose session ended in a PIN lockout stay masked until reset.
module arbitro_cajero #(
    parameter int N_TERM  = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 200
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_TERM-1:0] solicitud,
    input  logic [N_TERM-1:0] liberar,
    input  logic              core_fin,
    input  logic              core_bloqueo,
    output logic [N_TERM-1:0] concesion,
    output logic [ID_W-1:0]   id_activo,
    output logic              core_tarjeta,
    output logic              ocupado,
    output logic              fin_sesion,
    output logic              expirado,
    output logic [N_TERM-1:0] mascara
);

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        GRANT   = 4'b0010,
        BUSY    = 4'b0100,
        RELEASE = 4'b1000
    } state_t;

    localparam logic [ID_W:0]     N_EXT    = (ID_W+1)'(N_TERM);
    localparam logic [ID_W-1:0]   LAST_ID  = ID_W'(N_TERM - 1);
    localparam logic [7:0]        CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [N_TERM-1:0] ONE      = N_TERM'(1);

    state_t            state;
    logic [ID_W-1:0]   ptr;
    logic [7:0]        cnt;
    logic [N_TERM-1:0] elegibles;
    logic              hallado;
    logic [ID_W-1:0]   elegido;
    logic [ID_W:0]     suma;
    logic              por_fin;
    logic              por_tiempo;
    logic              fin_busy;

    assign elegibles  = solicitud & ~mascara;
    assign por_fin    = core_fin | liberar[id_activo];
    assign por_tiempo = (cnt == CNT_LAST);
    assign fin_busy   = por_fin | core_bloqueo | por_tiempo;

    // First eligible terminal scanning upward from ptr, wrapping modulo N_TERM.
    always_comb begin
        hallado = 1'b0;
        elegido = '0;
        suma    = '0;
        for (int unsigned i = 0; i < N_TERM; i++) begin
            suma = {1'b0, ptr} + (ID_W+1)'(i);
            if (suma >= N_EXT) suma = suma - N_EXT;
            if (!hallado && elegibles[suma[ID_W-1:0]]) begin
                hallado = 1'b1;
                elegido = suma[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            ptr          <= '0;
            id_activo    <= '0;
            cnt          <= '0;
            mascara      <= '0;
            concesion    <= '0;
            core_tarjeta <= 1'b0;
            ocupado      <= 1'b0;
            fin_sesion   <= 1'b0;
            expirado     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hallado) begin
                        state        <= GRANT;
                        id_activo    <= elegido;
                        concesion    <= ONE << elegido;
                        core_tarjeta <= 1'b1;
                        ocupado      <= 1'b1;
                        cnt          <= '0;
                    end
                end
                GRANT: begin
                    state        <= BUSY;
                    core_tarjeta <= 1'b0;
                    cnt          <= '0;
                end
                BUSY: begin
                    // Timeout counts as expiry only when no other exit cause coincides.
                    if (fin_busy) begin
                        state      <= RELEASE;
                        concesion  <= '0;
                        fin_sesion <= 1'b1;
                        expirado   <= por_tiempo & ~por_fin & ~core_bloqueo;
                        if (core_bloqueo) mascara[id_activo] <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RELEASE: begin
                    state      <= IDLE;
                    fin_sesion <= 1'b0;
                    expirado   <= 1'b0;
                    ocupado    <= 1'b0;
                    ptr        <= (id_activo == LAST_ID) ? '0 : id_activo + ID_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_cajero.sv
// Scoreboard bench for arbitro_cajero: stimulus pushes expected grants/releases from a
// session-level model; a negedge monitor pops and compares whenever the DUT presents them.
module tb_arbitro_cajero;

    localparam int N  = 4;
    localparam int TO = 10;

    typedef struct {
        logic       expirado;
        logic [3:0] mascara;
        int         len;
    } rel_t;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] solicitud;
    logic [3:0] liberar;
    logic       core_fin;
    logic       core_bloqueo;
    logic [3:0] concesion;
    logic [1:0] id_activo;
    logic       core_tarjeta;
    logic       ocupado;
    logic       fin_sesion;
    logic       expirado;
    logic [3:0] mascara;

    int   gq[$];
    rel_t rq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr = 0;
    logic [3:0] m_mask = '0;
    logic [3:0] lib_force = '0;
    logic flush = 1'b0;
    logic mon_en = 1'b0;
    logic in_sess = 1'b0;
    int   cyc = 0;
    int   cur_id = 0;
    rel_t r_mon;

    always #5 clock = ~clock;

    arbitro_cajero #(.N_TERM(N), .ID_W(2), .TIMEOUT(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .solicitud    (solicitud),
        .liberar      (liberar),
        .core_fin     (core_fin),
        .core_bloqueo (core_bloqueo),
        .concesion    (concesion),
        .id_activo    (id_activo),
        .core_tarjeta (core_tarjeta),
        .ocupado      (ocupado),
        .fin_sesion   (fin_sesion),
        .expirado     (expirado),
        .mascara      (mascara)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] oh(input int i);
        return 4'(1) << i;
    endfunction

    // Round-robin rule: first eligible terminal at or after the pointer, wrapping.
    function automatic int model_pick(input logic [3:0] elig);
        for (int i = 0; i < N; i++) begin
            int t;
            t = (m_ptr + i) % N;
            if (elig[2'(t)]) return t;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        if (flush) begin
            chk("reset_outputs",
                32'({concesion, id_activo, core_tarjeta, ocupado, fin_sesion, expirado, mascara}), 32'(0));
            in_sess = 1'b0;
        end else if (mon_en) begin
            if (core_tarjeta === 1'b1) begin
                if (gq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: concesion=%b, expected no grant", concesion);
                end else begin
                    cur_id = gq.pop_front();
                    chk("grant_onehot", 32'(concesion), 32'(oh(cur_id)));
                    chk("grant_id", 32'(id_activo), 32'(cur_id));
                    chk("grant_ocupado", 32'(ocupado), 32'(1));
                end
                in_sess = 1'b1;
                cyc = 0;
            end else if (fin_sesion === 1'b1) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_release: fin_sesion=1, expected none");
                end else begin
                    r_mon = rq.pop_front();
                    chk("release_expirado", 32'(expirado), 32'(r_mon.expirado));
                    chk("release_mascara", 32'(mascara), 32'(r_mon.mascara));
                    chk("release_concesion", 32'({ocupado, concesion}), 32'({1'b1, 4'b0000}));
                    chk("busy_length", 32'(cyc), 32'(r_mon.len));
                end
                in_sess = 1'b0;
            end else if (in_sess) begin
                cyc++;
                chk("busy_hold", 32'({ocupado, expirado, concesion}), 32'({1'b1, 1'b0, oh(cur_id)}));
            end else begin
                chk("idle_outputs", 32'({ocupado, expirado, concesion}), 32'(0));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        solicitud    = '0;
        liberar      = '0;
        core_fin     = 1'b0;
        core_bloqueo = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_inputs();
        step();
        reset  = 1'b1;
        flush  = 1'b1;
        m_ptr  = 0;
        m_mask = '0;
        step();
        flush = 1'b0;
    endtask

    // causes: bit0 core_fin, bit1 core_bloqueo, bit2 liberar[granted]; none means run to timeout.
    task automatic run_session(input logic [3:0] sol, input logic [2:0] causes,
                               input int blen_in, input bit do_rst);
        logic [3:0] elig;
        logic [3:0] o;
        int         id;
        int         blen;
        rel_t       r;
        blen = (causes == 3'b000 && !do_rst) ? TO : blen_in;
        if (blen > TO) blen = TO;
        if (blen < 1) blen = 1;
        elig = sol & ~m_mask;
        solicitud = sol;
        if (elig == 4'b0000) begin
            repeat (3) step();
            return;
        end
        id = model_pick(elig);
        o  = oh(id);
        gq.push_back(id);
        step();
        solicitud = 4'($urandom);
        core_fin  = 1'($urandom);
        liberar   = 4'($urandom);
        for (int k = 1; k <= blen; k++) begin
            step();
            solicitud = 4'($urandom);
            if (do_rst && k == blen) begin
                do_reset();
                return;
            end
            core_fin     = (k == blen) && causes[0];
            core_bloqueo = (k == blen) && causes[1];
            liberar      = ((4'($urandom) | lib_force) & ~o) | ((k == blen && causes[2]) ? o : 4'b0000);
        end
        r.expirado = (causes == 3'b000);
        r.mascara  = m_mask | (causes[1] ? o : 4'b0000);
        r.len      = blen;
        rq.push_back(r);
        m_mask = r.mascara;
        m_ptr  = (id + 1) % N;
        step();
        clear_inputs();
        solicitud = 4'($urandom);
        step();
    endtask

    initial begin
        logic [2:0] c;
        int         bl;
        reset = 1'b0;
        clear_inputs();
        step();
        do_reset();
        mon_en = 1'b1;

        run_session(4'b0001, 3'b001, 5, 1'b0);
        run_session(4'b0001, 3'b000, 3, 1'b1);
        repeat (5) run_session(4'b1111, 3'b001, 2, 1'b0);
        run_session(4'b0100, 3'b000, TO, 1'b0);
        run_session(4'b0100, 3'b001, 2, 1'b0);
        run_session(4'b0011, 3'b001, 2, 1'b0);
        run_session(4'b0011, 3'b010, 4, 1'b0);
        run_session(4'b0011, 3'b001, 2, 1'b0);
        run_session(4'b0010, 3'b001, 2, 1'b0);
        run_session(4'b1000, 3'b001, TO, 1'b0);
        lib_force = 4'b1000;
        run_session(4'b0001, 3'b001, 4, 1'b0);
        lib_force = 4'b0000;

        for (int s = 0; s < 60; s++) begin
            c = 3'($urandom);
            if ($countones(m_mask) >= 2) c[1] = 1'b0;
            bl = (c == 3'b000) ? TO : int'($urandom_range(1, TO));
            run_session(4'($urandom), c, bl, ($urandom_range(0, 19) == 0));
        end

        repeat (3) step();
        chk("pending_grants", 32'(gq.size()), 32'(0));
        chk("pending_releases", 32'(rq.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_cajero.md
# arbitro_cajero

Round-robin session arbiter that shares a single `cajero` transaction core between several card terminals. It accepts per-terminal session requests, grants exactly one terminal at a time, and pulses the core's card-received input. It closes the session on core completion, terminal release or timeout. Terminals whose session ended in a PIN lockout are permanently masked until reset.

## Interface
- `N_TERM`, 4: number of terminals, 2..8.
- `ID_W`, 2: width of terminal index; 2^ID_W >= N_TERM.
- `TIMEOUT`, 200: max BUSY cycles per session, 1..255.

- `clock`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `solicitud`  in  N_TERM  per-terminal session request, level.
- `liberar`  in  N_TERM  per-terminal abort; only the granted terminal's bit is honoured.
- `core_fin`  in  1  core reports transaction done (balance_actualizado | fondos_insuficientes), 1-cycle pulse.
- `core_bloqueo`  in  1  core reports lockout, level.
- `concesion`  out  N_TERM  one-hot grant; all-zero when no session.
- `id_activo`  out  ID_W  index of the granted terminal; holds last value when idle.
- `core_tarjeta`  out  1  1-cycle pulse to core `tarjeta_recibida`.
- `ocupado`  out  1  high in GRANT, BUSY, RELEASE.
- `fin_sesion`  out  1  1-cycle pulse in RELEASE.
- `expirado`  out  1  1-cycle pulse in RELEASE when the session ended by timeout.
- `mascara`  out  N_TERM  locked-out terminals.

## Operation
- States: IDLE, GRANT, BUSY, RELEASE. Encoding is one-hot, 4 bits.
- Eligible set = `solicitud & ~mascara`.
- IDLE: if eligible set is nonzero, pick the first eligible index scanning upward from `ptr` with wrap modulo N_TERM. Latch it into `id_activo`, then go to GRANT. Otherwise stay in IDLE.
- GRANT, one cycle: `concesion[id_activo]`=1, `core_tarjeta`=1, timeout counter cleared to 0. Always goes to BUSY.
- BUSY: `concesion` held and the counter increments each cycle. Exit to RELEASE on the first of these:
  - `core_fin`=1
  - `core_bloqueo`=1
  - `liberar[id_activo]`=1
  - counter == TIMEOUT-1
- Simultaneous exit causes: `core_bloqueo` sets `mascara[id_activo]`; `core_fin` or `liberar` suppress `expirado`. `expirado` is set only when the timeout is the sole cause.
- RELEASE, one cycle: `concesion`=0, `fin_sesion`=1. `ptr` <= `id_activo`+1 with wrap. Go to IDLE.
- `solicitud` deasserting during GRANT or BUSY has no effect; only `liberar` aborts a session.
- `liberar` bits of non-granted terminals are ignored.
- A request that stays high after its own session is re-granted only after every other eligible requester has been served (round-robin fairness).
- `mascara` bits only set, never clear, except by reset. If all terminals are masked, the block stays in IDLE.
- Counter is 8 bits and never wraps; it saturates at TIMEOUT-1.

## Timing
- Reset (`reset`=0 at an edge): state=IDLE, `ptr`=0, `id_activo`=0, counter=0, `mascara`=0. All outputs 0 on the following cycle.
- Reset asserted mid-session aborts immediately. There is no `fin_sesion` pulse, and `concesion` drops the next cycle.
- Request latency: `solicitud` high at edge k (state IDLE) gives state GRANT at k+1. `concesion` and `core_tarjeta` are high during cycle k+1.
- All outputs are registered or decoded from registered state. There is no combinational path from inputs to outputs.
- Exit cause seen at edge j in BUSY gives RELEASE during cycle j+1 and IDLE during j+2. The earliest next GRANT is during j+3.
- Timeout: BUSY entered at edge b, no other cause present, gives RELEASE at edge b+TIMEOUT. BUSY lasts exactly TIMEOUT cycles.
- Minimum session length is 3 cycles (GRANT, BUSY, RELEASE).

## Test plan
- Single requester: reset, `solicitud`=0001, `core_fin` pulsed 5 cycles after GRANT.
  - `concesion`=0001 from GRANT through BUSY, `core_tarjeta` 1 pulse.
  - `fin_sesion` pulse 1 cycle after `core_fin`, `expirado`=0.
- Round-robin: `solicitud`=1111 held, every session ended by `core_fin` after 2 BUSY cycles.
  - Grant order 0,1,2,3,0.
  - Exactly 2 idle/release cycles between consecutive grants.
- Timeout: TIMEOUT=10, `solicitud`=0100, no `core_fin`.
  - BUSY lasts 10 cycles, `fin_sesion`=`expirado`=1 in the same cycle.
  - Next grant goes to terminal 2 only if it is still requesting.
- Lockout and mask: `core_bloqueo`=1 during terminal 1's session with `solicitud`=0011.
  - `mascara`=0010, terminal 0 granted next, terminal 1 never granted again until reset.
- Simultaneous and abort cases:
  - `core_fin` and timeout in the same cycle gives `expirado`=0.
  - `liberar`=1000 while terminal 0 is granted is ignored.
  - `reset`=0 mid-BUSY gives all outputs 0 next cycle, `mascara`=0 and `ptr`=0.
